// File: rtl/xfcp_pkg.sv
// XFCP switch shared definitions: protocol bytes, ID block sizes,
// downstream FSM states and string byte-order helper.
package xfcp_pkg;

    localparam logic [7:0] XFCP_SEP      = 8'hFE;
    localparam logic [7:0] TYPE_ID_REQ   = 8'h00;
    localparam logic [7:0] TYPE_ID_RESP  = 8'h01;

    localparam int RESP_HDR_LEN = 2;
    localparam int ID_BLK_LEN   = 32;
    localparam int EXT_BLK_LEN  = 32;
    localparam int STR_LEN      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_LOCAL_TYPE,
        ST_ID_RESP,
        ST_DROP
    } dn_state_t;

    // String literals are right-justified; reorder so byte 0 is the first char.
    function automatic logic [STR_LEN*8-1:0] str_first_low(
        input logic [STR_LEN*8-1:0] s
    );
        logic [STR_LEN*8-1:0] r;
        int m;
        r = '0;
        m = -1;
        for (int i = 0; i < STR_LEN; i++) begin
            if (s[8*i +: 8] != 8'h00) begin
                m = i;
            end
        end
        for (int k = 0; k < STR_LEN; k++) begin
            if (k <= m) begin
                r[8*k +: 8] = s[8*(m-k) +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xfcp_arb_mux.sv
// Round-robin packet arbiter/mux; each granted packet is preceded by
// its input index, except the optional local input in the last slot.
module xfcp_arb_mux
    import xfcp_pkg::*;
#(
    parameter int   N          = 5,
    parameter logic LOCAL_LAST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*8-1:0] i_s_tdata,
    input  logic [N-1:0]   i_s_tvalid,
    output logic [N-1:0]   o_s_tready,
    input  logic [N-1:0]   i_s_tlast,
    input  logic [N-1:0]   i_s_tuser,
    output logic [7:0]     o_m_tdata,
    output logic           o_m_tvalid,
    input  logic           i_m_tready,
    output logic           o_m_tlast,
    output logic           o_m_tuser
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic          r_gnt_valid;
    logic [IW-1:0] r_gnt;
    logic [IW-1:0] r_last;
    logic          r_pfx;
    logic [7:0]    r_m_data;
    logic          r_m_valid;
    logic          r_m_last;
    logic          r_m_user;

    logic          w_m_ready;
    logic          w_pfx_fire;
    logic          w_s_fire;
    logic          w_pick_ok;
    logic [IW-1:0] w_pick;
    logic [7:0]    w_s_data;
    int            w_idx;

    assign w_m_ready  = !r_m_valid || i_m_tready;
    assign w_pfx_fire = r_gnt_valid && r_pfx && w_m_ready;
    assign w_s_data   = i_s_tdata[8*int'(r_gnt) +: 8];
    assign w_s_fire   = r_gnt_valid && !r_pfx && w_m_ready
                        && i_s_tvalid[r_gnt];

    // Walk from lowest to highest priority so the closest requester wins.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_idx     = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % N;
            if (i_s_tvalid[w_idx]) begin
                w_pick_ok = 1'b1;
                w_pick    = IW'(w_idx);
            end
        end
    end

    always_comb begin
        o_s_tready = '0;
        for (int n = 0; n < N; n++) begin
            o_s_tready[n] = r_gnt_valid && !r_pfx && w_m_ready
                            && (r_gnt == IW'(n));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_valid <= 1'b0;
            r_gnt       <= '0;
            r_last      <= LAST_IDX;
            r_pfx       <= 1'b0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_user    <= 1'b0;
        end else begin
            if (!r_gnt_valid && w_pick_ok) begin
                r_gnt_valid <= 1'b1;
                r_gnt       <= w_pick;
                r_last      <= w_pick;
                r_pfx       <= !(LOCAL_LAST && (w_pick == LAST_IDX));
            end
            if (w_pfx_fire) begin
                r_m_data  <= 8'(r_gnt);
                r_m_valid <= 1'b1;
                r_m_last  <= 1'b0;
                r_m_user  <= 1'b0;
                r_pfx     <= 1'b0;
            end else if (w_s_fire) begin
                r_m_data  <= w_s_data;
                r_m_valid <= 1'b1;
                r_m_last  <= i_s_tlast[r_gnt];
                r_m_user  <= i_s_tuser[r_gnt];
                if (i_s_tlast[r_gnt]) begin
                    r_gnt_valid <= 1'b0;
                end
            end else if (i_m_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_m_tdata  = r_m_data;
    assign o_m_tvalid = r_m_valid;
    assign o_m_tlast  = r_m_last;
    assign o_m_tuser  = r_m_user;

endmodule

// File: rtl/xfcp_switch.sv
// XFCP switch node: routes requests down by path byte, merges
// responses up with a port prefix, and answers local ID requests.
module xfcp_switch
    import xfcp_pkg::*;
#(
    parameter int           PORTS           = 4,
    parameter logic [15:0]  XFCP_ID_TYPE    = 16'h0100,
    parameter logic [127:0] XFCP_ID_STR     = "XFCP Switch",
    parameter logic [127:0] XFCP_EXT_ID     = '0,
    parameter logic [127:0] XFCP_EXT_ID_STR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         up_xfcp_in_tdata,
    input  logic               up_xfcp_in_tvalid,
    output logic               up_xfcp_in_tready,
    input  logic               up_xfcp_in_tlast,
    input  logic               up_xfcp_in_tuser,
    output logic [7:0]         up_xfcp_out_tdata,
    output logic               up_xfcp_out_tvalid,
    input  logic               up_xfcp_out_tready,
    output logic               up_xfcp_out_tlast,
    output logic               up_xfcp_out_tuser,
    input  logic [PORTS*8-1:0] down_xfcp_in_tdata,
    input  logic [PORTS-1:0]   down_xfcp_in_tvalid,
    output logic [PORTS-1:0]   down_xfcp_in_tready,
    input  logic [PORTS-1:0]   down_xfcp_in_tlast,
    input  logic [PORTS-1:0]   down_xfcp_in_tuser,
    output logic [PORTS*8-1:0] down_xfcp_out_tdata,
    output logic [PORTS-1:0]   down_xfcp_out_tvalid,
    input  logic [PORTS-1:0]   down_xfcp_out_tready,
    output logic [PORTS-1:0]   down_xfcp_out_tlast,
    output logic [PORTS-1:0]   down_xfcp_out_tuser
);

    localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [8:0] PORTS9 = 9'(PORTS);
    localparam bit HAS_EXT = (XFCP_EXT_ID != '0);
    localparam int RESP_LEN = RESP_HDR_LEN + ID_BLK_LEN
                              + (HAS_EXT ? EXT_BLK_LEN : 0);
    localparam logic [6:0] RESP_LAST = 7'(RESP_LEN - 1);

    // ID block image, byte i at bits [8i+7:8i].
    localparam logic [511:0] ID_ROM = {
        str_first_low(XFCP_EXT_ID_STR),
        XFCP_EXT_ID,
        str_first_low(XFCP_ID_STR),
        112'h0,
        XFCP_ID_TYPE
    };

    dn_state_t   r_state;
    dn_state_t   w_state_nxt;
    logic        r_run;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_out_sel;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_out_user;
    logic        r_id_req;
    logic [6:0]  r_id_cnt;

    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_ready;
    logic        w_is_port;
    logic        w_is_idreq;
    logic [PORTS-1:0] w_dn_valid;
    logic        w_id_valid;
    logic        w_id_ready;
    logic        w_id_last;
    logic [7:0]  w_id_data;
    logic [5:0]  w_rom_idx;
    logic [PORTS:0] w_s_tready;

    assign w_out_ready = !r_out_valid || down_xfcp_out_tready[r_out_sel];
    assign w_is_port   = {1'b0, up_xfcp_in_tdata} < PORTS9;
    assign w_is_idreq  = up_xfcp_in_tdata == TYPE_ID_REQ;
    assign w_in_fire   = up_xfcp_in_tvalid && w_in_ready;

    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            ST_IDLE:       w_in_ready = r_run;
            ST_ROUTE:      w_in_ready = w_out_ready;
            ST_LOCAL_TYPE: w_in_ready = 1'b1;
            ST_DROP:       w_in_ready = 1'b1;
            ST_ID_RESP:    w_in_ready = 1'b0;
            default:       w_in_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_in_fire && !up_xfcp_in_tlast) begin
                    if (w_is_port) begin
                        w_state_nxt = ST_ROUTE;
                    end else if (up_xfcp_in_tdata == XFCP_SEP) begin
                        w_state_nxt = ST_LOCAL_TYPE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                if (w_in_fire && up_xfcp_in_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCAL_TYPE: begin
                if (w_in_fire) begin
                    if (!up_xfcp_in_tlast) begin
                        w_state_nxt = ST_DROP;
                    end else if (w_is_idreq && !up_xfcp_in_tuser) begin
                        w_state_nxt = ST_ID_RESP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (w_in_fire && up_xfcp_in_tlast) begin
                    w_state_nxt = (r_id_req && !up_xfcp_in_tuser)
                                  ? ST_ID_RESP : ST_IDLE;
                end
            end
            ST_ID_RESP: begin
                if (w_id_ready && w_id_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ID request with trailing bytes is answered once they are drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_sel    <= '0;
            r_id_req <= 1'b0;
            r_id_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_state == ST_IDLE && w_in_fire) begin
                r_sel    <= SW'(up_xfcp_in_tdata);
                r_id_req <= 1'b0;
            end
            if (r_state == ST_LOCAL_TYPE && w_in_fire) begin
                r_id_req <= w_is_idreq;
            end
            if (w_id_ready) begin
                r_id_cnt <= w_id_last ? 7'd0 : r_id_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
            r_out_sel   <= '0;
        end else if (r_state == ST_ROUTE && w_in_fire) begin
            r_out_data  <= up_xfcp_in_tdata;
            r_out_valid <= 1'b1;
            r_out_last  <= up_xfcp_in_tlast;
            r_out_user  <= up_xfcp_in_tuser;
            r_out_sel   <= r_sel;
        end else if (r_out_valid && down_xfcp_out_tready[r_out_sel]) begin
            r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        w_dn_valid = '0;
        for (int n = 0; n < PORTS; n++) begin
            w_dn_valid[n] = r_out_valid && (r_out_sel == SW'(n));
        end
    end

    assign up_xfcp_in_tready    = w_in_ready;
    assign down_xfcp_out_tdata  = {PORTS{r_out_data}};
    assign down_xfcp_out_tvalid = w_dn_valid;
    assign down_xfcp_out_tlast  = w_dn_valid & {PORTS{r_out_last}};
    assign down_xfcp_out_tuser  = w_dn_valid & {PORTS{r_out_user}};

    assign w_id_valid = r_state == ST_ID_RESP;
    assign w_id_last  = r_id_cnt == RESP_LAST;
    assign w_id_ready = w_id_valid && w_s_tready[PORTS];
    assign w_rom_idx  = 6'(r_id_cnt - 7'd2);

    always_comb begin
        w_id_data = ID_ROM[{w_rom_idx, 3'b000} +: 8];
        if (r_id_cnt == 7'd0) begin
            w_id_data = XFCP_SEP;
        end else if (r_id_cnt == 7'd1) begin
            w_id_data = TYPE_ID_RESP;
        end
    end

    assign down_xfcp_in_tready = w_s_tready[PORTS-1:0];

    xfcp_arb_mux #(
        .N          (PORTS + 1),
        .LOCAL_LAST (1'b1)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_s_tdata  ({w_id_data, down_xfcp_in_tdata}),
        .i_s_tvalid ({w_id_valid, down_xfcp_in_tvalid}),
        .o_s_tready (w_s_tready),
        .i_s_tlast  ({w_id_last, down_xfcp_in_tlast}),
        .i_s_tuser  ({1'b0, down_xfcp_in_tuser}),
        .o_m_tdata  (up_xfcp_out_tdata),
        .o_m_tvalid (up_xfcp_out_tvalid),
        .i_m_tready (up_xfcp_out_tready),
        .o_m_tlast  (up_xfcp_out_tlast),
        .o_m_tuser  (up_xfcp_out_tuser)
    );

endmodule

// File: tb/tb_xfcp_switch.sv
// Self-checking bench for xfcp_switch: vector table, hand sequences
// and randomized traffic against a packet-level reference model.
module tb_xfcp_switch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ui_data = '0;
    logic        ui_valid = 1'b0;
    logic        ui_ready;
    logic        ui_last = 1'b0;
    logic        ui_user = 1'b0;
    logic [7:0]  uo_data;
    logic        uo_valid;
    logic        uo_ready = 1'b1;
    logic        uo_last;
    logic        uo_user;
    logic [31:0] di_data = '0;
    logic [3:0]  di_valid = '0;
    logic [3:0]  di_ready;
    logic [3:0]  di_last = '0;
    logic [3:0]  di_user = '0;
    logic [31:0] do_data;
    logic [3:0]  do_valid;
    logic [3:0]  do_ready = '1;
    logic [3:0]  do_last;
    logic [3:0]  do_user;

    xfcp_switch #(.PORTS(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .up_xfcp_in_tdata     (ui_data),
        .up_xfcp_in_tvalid    (ui_valid),
        .up_xfcp_in_tready    (ui_ready),
        .up_xfcp_in_tlast     (ui_last),
        .up_xfcp_in_tuser     (ui_user),
        .up_xfcp_out_tdata    (uo_data),
        .up_xfcp_out_tvalid   (uo_valid),
        .up_xfcp_out_tready   (uo_ready),
        .up_xfcp_out_tlast    (uo_last),
        .up_xfcp_out_tuser    (uo_user),
        .down_xfcp_in_tdata   (di_data),
        .down_xfcp_in_tvalid  (di_valid),
        .down_xfcp_in_tready  (di_ready),
        .down_xfcp_in_tlast   (di_last),
        .down_xfcp_in_tuser   (di_user),
        .down_xfcp_out_tdata  (do_data),
        .down_xfcp_out_tvalid (do_valid),
        .down_xfcp_out_tready (do_ready),
        .down_xfcp_out_tlast  (do_last),
        .down_xfcp_out_tuser  (do_user)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit rnd_rdy = 1'b0;

    // {port, user, last, data}
    logic [11:0] dn_q[$];
    // {user, last, data}
    logic [9:0]  up_q[$];
    logic [9:0]  exp_id[$];
    logic [11:0] exp_dn[$];
    logic [11:0] exp_rsp[$];

    typedef struct {
        logic [63:0] pk;
        int          len;
        bit          u;
        int          port;
        int          n;
    } vec_t;
    vec_t vt[$];

    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (do_valid[p] && do_ready[p]) begin
                dn_q.push_back({2'(p), do_user[p], do_last[p],
                                do_data[p*8 +: 8]});
            end
        end
        if (uo_valid && uo_ready) begin
            up_q.push_back({uo_user, uo_last, uo_data});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) begin
            do_ready = 4'($urandom);
            uo_ready = 1'($urandom_range(1));
        end else begin
            do_ready = '1;
            uo_ready = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic up_send(input logic [7:0] pk[$], input bit u,
                           input int gp, input bit term,
                           output int stalls);
        int t;
        stalls = 0;
        for (int i = 0; i < pk.size(); i++) begin
            while (gp > 0 && $urandom_range(99) < gp) begin
                ui_valid = 1'b0;
                tick(1);
            end
            ui_data  = pk[i];
            ui_last  = term && (i == pk.size() - 1);
            ui_user  = ui_last && u;
            ui_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!ui_ready && t < 1000) begin
                stalls++;
                t++;
                @(negedge clk);
            end
            if (!ui_ready) begin
                chk("up_send handshake timeout", 0, 1);
                break;
            end
            tick(1);
        end
        ui_valid = 1'b0;
        ui_last  = 1'b0;
        ui_user  = 1'b0;
    endtask

    task automatic dn_send(input int p, input logic [7:0] pk[$],
                           input bit u, input int gp);
        int t;
        for (int i = 0; i < pk.size(); i++) begin
            while (gp > 0 && $urandom_range(99) < gp) begin
                di_valid[p] = 1'b0;
                tick(1);
            end
            di_data[p*8 +: 8] = pk[i];
            di_last[p]  = i == pk.size() - 1;
            di_user[p]  = (i == pk.size() - 1) && u;
            di_valid[p] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!di_ready[p] && t < 1000) begin
                t++;
                @(negedge clk);
            end
            if (!di_ready[p]) begin
                chk($sformatf("dn_send%0d handshake timeout", p), 0, 1);
                break;
            end
            tick(1);
        end
        di_valid[p] = 1'b0;
        di_last[p]  = 1'b0;
        di_user[p]  = 1'b0;
    endtask

    // Expected ID response built from the node's documented identity.
    task automatic mk_id();
        string s;
        logic [9:0] b[$];
        s = "XFCP Switch";
        b.push_back({2'b00, 8'hFE});
        b.push_back({2'b00, 8'h01});
        b.push_back({2'b00, 8'h00});
        b.push_back({2'b00, 8'h01});
        for (int i = 0; i < 14; i++) b.push_back(10'h000);
        for (int i = 0; i < 16; i++) begin
            b.push_back({2'b00, (i < s.len()) ? s[i] : 8'h00});
        end
        b[b.size()-1][8] = 1'b1;
        exp_id = b;
    endtask

    task automatic cmp_ports(input string nm, input logic [11:0] got[$],
                             input logic [11:0] expv[$]);
        logic [11:0] g[$];
        logic [11:0] e[$];
        for (int p = 0; p < 4; p++) begin
            g = {};
            e = {};
            foreach (got[i]) if (got[i][11:10] == 2'(p)) g.push_back(got[i]);
            foreach (expv[i]) if (expv[i][11:10] == 2'(p)) e.push_back(expv[i]);
            chk($sformatf("%s p%0d count", nm, p), g.size(), e.size());
            for (int i = 0; i < g.size() && i < e.size(); i++) begin
                chk($sformatf("%s p%0d byte%0d", nm, p, i), g[i], e[i]);
            end
        end
    endtask

    task automatic rnd_route(input int npk);
        logic [7:0] q[$];
        int port;
        int n;
        int st;
        bit u;
        for (int k = 0; k < npk; k++) begin
            port = (k == 0) ? 3 : $urandom_range(3);
            u    = (k == 0) ? 1'b1 : 1'($urandom_range(1));
            n    = $urandom_range(1, 6);
            q = {8'(port)};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            for (int i = 0; i < n; i++) begin
                exp_dn.push_back({2'(port), u && (i == n - 1),
                                  i == n - 1, q[i+1]});
            end
            up_send(q, u, 30, 1'b1, st);
        end
    endtask

    task automatic rsp_burst(input int p);
        logic [7:0] q[$];
        int n;
        bit u;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 6);
            u = 1'($urandom_range(1));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            for (int i = 0; i < n; i++) begin
                exp_rsp.push_back({2'(p), u && (i == n - 1),
                                   i == n - 1, q[i]});
            end
            dn_send(p, q, u, 30);
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [11:0] got[$];
        logic [9:0]  e4[$];
        int st;
        int t;
        int cur;
        int n_up;

        mk_id();

        // reset state
        #2 rst = 1'b1;
        tick(3);
        chk("rst up_in_tready", ui_ready, 0);
        chk("rst down_out_tvalid", do_valid, 0);
        chk("rst down_out_tdata", do_data, 0);
        chk("rst down_out_tlast/user", {do_last, do_user}, 0);
        chk("rst up_out_tvalid/last/user", {uo_valid, uo_last, uo_user}, 0);
        chk("rst up_out_tdata", uo_data, 0);
        rst = 1'b0;
        tick(2);

        // pk bytes left-aligned: byte 0 at [63:56]; port 4 = ID, -1 = none
        vt.push_back('{64'h01FE10AABB000000, 5, 1'b0, 1, 4});
        vt.push_back('{64'hFE00000000000000, 2, 1'b0, 4, 34});
        vt.push_back('{64'h07FE000000000000, 3, 1'b0, -1, 0});
        vt.push_back('{64'h03FE105500000000, 4, 1'b1, 3, 3});
        vt.push_back('{64'h00FE100102030000, 6, 1'b0, 0, 5});
        vt.push_back('{64'hFE05AA0000000000, 3, 1'b0, -1, 0});
        vt.push_back('{64'hFE00000000000000, 2, 1'b1, -1, 0});
        vt.push_back('{64'h0200000000000000, 1, 1'b0, -1, 0});
        vt.push_back('{64'hFE00000000000000, 1, 1'b0, -1, 0});
        vt.push_back('{64'hFE00112200000000, 4, 1'b0, 4, 34});
        vt.push_back('{64'hFF01000000000000, 2, 1'b0, -1, 0});
        vt.push_back('{64'h02FE123400000000, 4, 1'b0, 2, 3});

        for (int v = 0; v < vt.size(); v++) begin
            q = {};
            for (int i = 0; i < vt[v].len; i++) begin
                q.push_back(vt[v].pk[63-8*i -: 8]);
            end
            dn_q.delete();
            up_q.delete();
            up_send(q, vt[v].u, 0, 1'b1, st);
            tick(100);
            if (vt[v].port >= 0 && vt[v].port < 4) begin
                chk($sformatf("v%0d port count", v), dn_q.size(), vt[v].n);
                chk($sformatf("v%0d up idle", v), up_q.size(), 0);
                for (int i = 0; i < dn_q.size() && i + 1 < q.size(); i++) begin
                    chk($sformatf("v%0d byte%0d", v, i), dn_q[i],
                        {2'(vt[v].port),
                         vt[v].u && (i == q.size() - 2),
                         i == q.size() - 2, q[i+1]});
                end
            end else if (vt[v].port == 4) begin
                chk($sformatf("v%0d id count", v), up_q.size(), vt[v].n);
                chk($sformatf("v%0d down idle", v), dn_q.size(), 0);
                for (int i = 0; i < up_q.size() && i < exp_id.size(); i++) begin
                    chk($sformatf("v%0d id byte%0d", v, i), up_q[i], exp_id[i]);
                end
            end else begin
                chk($sformatf("v%0d drop down", v), dn_q.size(), 0);
                chk($sformatf("v%0d drop up", v), up_q.size(), 0);
                chk($sformatf("v%0d drop stalls", v), st, 0);
            end
        end

        // reset in the middle of a routed packet
        q = {8'h01, 8'hFE, 8'hAA};
        up_send(q, 1'b0, 0, 1'b0, st);
        ui_data  = 8'hBB;
        ui_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst up_in_tready", ui_ready, 0);
        chk("midrst down_out_tvalid", do_valid, 0);
        chk("midrst down_out_tdata", do_data, 0);
        chk("midrst up_out_tvalid", uo_valid, 0);
        ui_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        dn_q.delete();
        up_q.delete();
        q = {8'h02, 8'hFE, 8'h77};
        up_send(q, 1'b0, 0, 1'b1, st);
        tick(20);
        chk("postrst count", dn_q.size(), 2);
        if (dn_q.size() == 2) begin
            chk("postrst byte0", dn_q[0], {2'd2, 2'b00, 8'hFE});
            chk("postrst byte1", dn_q[1], {2'd2, 2'b01, 8'h77});
        end

        // two ports respond together; fresh reset leaves port 0 first
        up_q.delete();
        fork
            dn_send(0, '{8'hFE, 8'h01, 8'h55}, 1'b0, 0);
            dn_send(2, '{8'hFE, 8'h01, 8'h55}, 1'b0, 0);
        join
        tick(20);
        e4 = '{10'h000, 10'h0FE, 10'h001, 10'h155,
               10'h002, 10'h0FE, 10'h001, 10'h155};
        chk("merge count", up_q.size(), e4.size());
        for (int i = 0; i < up_q.size() && i < e4.size(); i++) begin
            chk($sformatf("merge byte%0d", i), up_q[i], e4[i]);
        end

        // randomized concurrent traffic with throttling everywhere
        dn_q.delete();
        up_q.delete();
        exp_dn.delete();
        exp_rsp.delete();
        rnd_rdy = 1'b1;
        fork
            rnd_route(12);
            rsp_burst(0);
            rsp_burst(1);
            rsp_burst(2);
            rsp_burst(3);
        join
        n_up = exp_rsp.size() + 16;
        t = 0;
        while ((dn_q.size() < exp_dn.size() || up_q.size() < n_up)
               && t < 5000) begin
            tick(1);
            t++;
        end
        chk("rand drain in time", t < 5000, 1);
        rnd_rdy = 1'b0;
        tick(20);
        cmp_ports("rand route", dn_q, exp_dn);
        got = {};
        cur = -1;
        foreach (up_q[i]) begin
            if (cur < 0) begin
                cur = int'(up_q[i][7:0]);
                chk("rand prefix range", cur < 4, 1);
            end else begin
                got.push_back({2'(cur), up_q[i]});
                if (up_q[i][8]) cur = -1;
            end
        end
        cmp_ports("rand merge", got, exp_rsp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
